psum_drain: RTL and testbench



---
 rtl/psum_drain.sv | 164 ++++++++++++++++
 tb/tb_psum_drain.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain.sv
// psum_drain: resolves a PE column's carry-save partial-sum pair with a two-stage
// split adder and streams the results out through a credit-guarded FIFO.
module psum_drain #(
  parameter int SIZE  = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SIZE+15:0]       psum0,
  input  logic [SIZE+15:0]       psum1,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SIZE+15:0]       out_data,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int W  = SIZE + 16;
  localparam int H  = W / 2;
  localparam int UW = W - H;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int KW = CW + 1;
  localparam logic [KW-1:0] DEPTH_K = KW'(DEPTH);
  localparam logic [CW-1:0] OCC_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  // stage 1: low-half sum with its carry, raw upper halves
  logic          s1_valid_r;
  logic [H:0]    s1_low_r;
  logic [UW-1:0] s1_hi0_r;
  logic [UW-1:0] s1_hi1_r;
  logic          s1_last_r;

  // stage 2: fully resolved result
  logic          s2_valid_r;
  logic [H-1:0]  s2_low_r;
  logic [UW-1:0] s2_up_r;
  logic          s2_last_r;

  logic [W:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] occ_r;

  logic [KW-1:0] credit_s;
  logic          in_ready_s;
  logic          accept_s;
  logic          out_valid_s;
  logic          pop_s;
  logic          push_s;
  logic [H:0]    low_sum_s;
  logic [UW-1:0] up_sum_s;
  logic [W:0]    head_s;

  // Handshakes, credit and adder halves; in_ready depends on state and rst only
  always_comb begin
    credit_s    = {1'b0, occ_r} + {{(KW-1){1'b0}}, s1_valid_r} + {{(KW-1){1'b0}}, s2_valid_r};
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    if (rst) begin
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
    end else begin
      in_ready_s  = (credit_s < DEPTH_K);
      out_valid_s = (occ_r != {CW{1'b0}});
    end
    accept_s  = in_valid && in_ready_s;
    pop_s     = out_valid_s && out_ready;
    push_s    = s2_valid_r;
    low_sum_s = {1'b0, psum0[H-1:0]} + {1'b0, psum1[H-1:0]};
    up_sum_s  = s1_hi0_r + s1_hi1_r + {{(UW-1){1'b0}}, s1_low_r[H]};
    head_s    = mem_r[rd_ptr_r];
  end

  // Output view of the FIFO head, forced quiet while empty or in reset
  always_comb begin
    in_ready  = in_ready_s;
    out_valid = out_valid_s;
    out_data  = {W{1'b0}};
    out_last  = 1'b0;
    occupancy = {CW{1'b0}};
    if (out_valid_s) begin
      out_data = head_s[W-1:0];
      out_last = head_s[W];
    end else begin
      out_data = {W{1'b0}};
      out_last = 1'b0;
    end
    if (rst) begin
      occupancy = {CW{1'b0}};
    end else begin
      occupancy = occ_r;
    end
  end

  // Stage 1 register: captures an accepted pair
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_low_r   <= {(H+1){1'b0}};
      s1_hi0_r   <= {UW{1'b0}};
      s1_hi1_r   <= {UW{1'b0}};
      s1_last_r  <= 1'b0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_low_r  <= low_sum_s;
        s1_hi0_r  <= psum0[W-1:H];
        s1_hi1_r  <= psum1[W-1:H];
        s1_last_r <= in_last;
      end
    end
  end

  // Stage 2 register: upper half absorbs the low-half carry
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_low_r   <= {H{1'b0}};
      s2_up_r    <= {UW{1'b0}};
      s2_last_r  <= 1'b0;
    end else begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_low_r  <= s1_low_r[H-1:0];
        s2_up_r   <= up_sum_s;
        s2_last_r <= s1_last_r;
      end
    end
  end

  // FIFO storage; credit accounting guarantees there is room on every push
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_r[wr_ptr_r] <= {s2_last_r, s2_up_r, s2_low_r};
    end
  end

  // FIFO pointers and occupancy counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      occ_r    <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_ONE;
        2'b01:   occ_r <= occ_r - OCC_ONE;
        default: occ_r <= occ_r;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed checks of psum_drain (SIZE=16, DEPTH=8) against
// hand-computed sums, latency, credit backpressure and reset behaviour.
module tb_psum_drain;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] psum0;
  logic [31:0] psum1;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [3:0]  occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  psum_drain #(.SIZE(16), .DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .psum0(psum0), .psum1(psum1), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one pair, wait for its result and pop it (out_ready must be 1)
  task automatic push_expect(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp, input string tag);
    int cnt;
    in_valid = 1'b1; psum0 = a; psum1 = b; in_last = 1'b0;
    tick;
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 10) begin
      tick;
      cnt++;
    end
    check({tag, "_lat"}, cnt, 3);
    check({tag, "_data"}, out_data, exp);
    tick;
  endtask

  initial begin
    logic [32:0] q[$];
    logic [32:0] e;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    int idx, sent, got, drops, maxocc;
    logic rdy;

    rst = 1'b1; in_valid = 1'b0; psum0 = 32'h0; psum1 = 32'h0;
    in_last = 1'b0; out_ready = 1'b0;
    tick; tick;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_occ", occupancy, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // carry across the half boundary, exact latency
    out_ready = 1'b1;
    in_valid = 1'b1; psum0 = 32'h0000FFFF; psum1 = 32'h00000001;
    tick;
    in_valid = 1'b0;
    check("carry_c1_valid", out_valid, 0);
    tick;
    check("carry_c2_valid", out_valid, 0);
    tick;
    check("carry_c3_valid", out_valid, 1);
    check("carry_data", out_data, 32'h00010000);
    check("carry_occ", occupancy, 1);
    tick;
    check("carry_occ_after", occupancy, 0);
    check("carry_valid_after", out_valid, 0);

    push_expect(32'hFFFFFFFF, 32'h00000002, 32'h00000001, "wrap1");
    push_expect(32'h80000000, 32'h80000000, 32'h00000000, "wrap2");

    // fill under backpressure
    out_ready = 1'b0; in_valid = 1'b1; idx = 0;
    for (int c = 0; c < 12; c++) begin
      psum0 = 32'(idx); psum1 = 32'(idx * 256); in_last = (idx == 7);
      rdy = in_ready;
      tick;
      if (rdy) begin
        idx++;
        if (idx == 8) begin
          check("fill_rdy_at8", in_ready, 0);
          check("fill_occ_at8", occupancy, 6);
          tick; tick;
          check("fill_occ_plus2", occupancy, 8);
        end
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("fill_accepted", idx, 8);
    check("fill_occ", occupancy, 8);
    check("fill_rdy_full", in_ready, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("fill_out_valid", out_valid, 1);
      check("fill_out_data", out_data, 32'(i * 257));
      check("fill_out_last", out_last, (i == 7));
      tick;
      if (i == 0) check("fill_rdy_back", in_ready, 1);
    end
    check("fill_empty", out_valid, 0);

    // full-rate random stream
    sent = 0; got = 0; drops = 0; maxocc = 0;
    for (int c = 0; c < 120; c++) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("stream_extra", 1, 0);
        end else begin
          e = q.pop_front();
          check("stream_data", out_data, e[31:0]);
          check("stream_last", out_last, e[32]);
          got++;
        end
      end
      if (sent < 100) begin
        a = $urandom; b = $urandom; s = a + b;
        in_valid = 1'b1; psum0 = a; psum1 = b; in_last = (sent == 99);
        if (!in_ready) drops++;
        else begin
          q.push_back({in_last, s});
          sent++;
        end
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      if (int'(occupancy) > maxocc) maxocc = int'(occupancy);
      tick;
    end
    check("stream_sent", sent, 100);
    check("stream_got", got, 100);
    check("stream_drops", drops, 0);
    check("stream_maxocc_le2", (maxocc <= 2), 1);

    // pop pulse while full, refilled by one new pair
    out_ready = 1'b0; in_valid = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 8; i++) begin
      psum0 = 32'h1000 + 32'(i); psum1 = 32'h0;
      tick;
    end
    in_valid = 1'b0;
    tick; tick;
    check("pp_occ_full", occupancy, 8);
    out_ready = 1'b1; in_valid = 1'b1; psum0 = 32'h0ABC0000; psum1 = 32'h00000001;
    tick;
    out_ready = 1'b0;
    check("pp_occ_popped", occupancy, 7);
    check("pp_rdy_credit", in_ready, 1);
    tick;
    in_valid = 1'b0;
    tick; tick;
    check("pp_occ_refull", occupancy, 8);
    check("pp_rdy_refull", in_ready, 0);
    out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check("pp_out_valid", out_valid, 1);
      check("pp_out_data", out_data, 32'h1000 + 32'(i));
      tick;
    end
    check("pp_new_valid", out_valid, 1);
    check("pp_new_data", out_data, 32'h0ABC0001);
    tick;
    check("pp_no_dup", out_valid, 0);

    // reset with 5 buffered and 2 in flight
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      psum0 = 32'h50 + 32'(i); psum1 = 32'h0;
      tick;
    end
    in_valid = 1'b0;
    check("mid_occ5", occupancy, 5);
    rst = 1'b1;
    #1;
    check("mid_rst_rdy", in_ready, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    tick;
    rst = 1'b0;
    #1;
    check("mid_post_valid", out_valid, 0);
    check("mid_post_occ", occupancy, 0);
    check("mid_post_rdy", in_ready, 1);
    tick; tick;
    check("mid_no_stale", out_valid, 0);
    out_ready = 1'b1;
    push_expect(32'h3, 32'h4, 32'h7, "mid_new");
    tick; tick;
    check("mid_final_empty", out_valid, 0);
    check("mid_final_occ", occupancy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
